simon_output_collector: RTL and testbench

//  Downstream stage of the bit-serial SIMON core. Captures the serial ciphertext
//  (one bit per clock while the core's valid is high) and packs it LSB-first into bytes.

---
 rtl/simon_output_collector.sv | 161 ++++++++++++++++
 tb/tb_simon_output_collector.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/simon_output_collector.sv
`default_nettype none
// ============================================================================
// Module   : simon_output_collector
// Purpose  : Packs serial SIMON ciphertext LSB-first into bytes and buffers
//            them in a first-word-fall-through FIFO with valid/ack output.
// Revision : 1.0 - initial release
// ============================================================================
module simon_output_collector #(
  parameter int BLOCK_BITS = 128,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cipher_in,
  input  logic                          valid_in,
  output logic [7:0]                    byte_out,
  output logic                          byte_valid,
  input  logic                          byte_ack,
  output logic                          block_done,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          clear_flags,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

  localparam int C_CNT_W = $clog2(BLOCK_BITS);
  localparam int C_PTR_W = $clog2(FIFO_DEPTH);
  localparam int C_LVL_W = C_PTR_W + 1;

  localparam logic [C_CNT_W-1:0] c_last_bit = C_CNT_W'(BLOCK_BITS - 1);
  localparam logic [C_CNT_W-1:0] c_cnt_one  = C_CNT_W'(1);
  localparam logic [C_PTR_W-1:0] c_ptr_one  = C_PTR_W'(1);
  localparam logic [C_LVL_W-1:0] c_lvl_one  = C_LVL_W'(1);
  localparam logic [C_LVL_W-1:0] c_lvl_full = C_LVL_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;

  logic [1:0]         r_state;
  logic [C_CNT_W-1:0] r_blk_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               r_block_done;
  logic               r_frame_err;
  logic               r_overflow;

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [C_PTR_W-1:0] r_wr_ptr;
  logic [C_PTR_W-1:0] r_rd_ptr;
  logic [C_LVL_W-1:0] r_level;
  logic [7:0]         r_byte_out;
  logic               r_byte_valid;

  logic               w_sample;
  logic               w_last;
  logic               w_abort;
  logic               w_byte_done;
  logic [7:0]         w_byte;
  logic               w_pop;
  logic               w_full;
  logic               w_push;
  logic               w_drop;
  logic [C_PTR_W-1:0] w_rd_nxt;
  logic [C_LVL_W-1:0] w_lvl_nxt;
  logic [7:0]         w_head_nxt;

  assign w_sample    = valid_in && ((r_state == S_IDLE) || (r_state == S_COLLECT));
  assign w_last      = w_sample && (r_blk_cnt == c_last_bit);
  assign w_abort     = (r_state == S_COLLECT) && !valid_in;
  assign w_byte_done = w_sample && (r_bit_idx == 3'd7);
  assign w_byte      = {cipher_in, r_shift[6:0]};

  assign w_pop    = r_byte_valid && byte_ack;
  assign w_full   = (r_level == c_lvl_full);
  assign w_push   = w_byte_done && (!w_full || w_pop);
  assign w_drop   = w_byte_done && w_full && !w_pop;
  assign w_rd_nxt = w_pop ? (r_rd_ptr + c_ptr_one) : r_rd_ptr;

  always_comb begin
    w_lvl_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_lvl_nxt = r_level + c_lvl_one;
      2'b01:   w_lvl_nxt = r_level - c_lvl_one;
      default: w_lvl_nxt = r_level;
    endcase
  end

  // The new head bypasses the memory when the pushed byte is the only entry left.
  always_comb begin
    w_head_nxt = r_mem[w_rd_nxt];
    if (w_push && ((r_level == '0) || ((r_level == c_lvl_one) && w_pop))) begin
      w_head_nxt = w_byte;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_blk_cnt    <= '0;
      r_bit_idx    <= 3'd0;
      r_shift      <= 8'h00;
      r_block_done <= 1'b0;
    end else begin
      r_block_done <= w_last;
      case (r_state)
        S_IDLE:    if (valid_in) r_state <= S_COLLECT;
        S_COLLECT: begin
          if (!valid_in)   r_state <= S_IDLE;
          else if (w_last) r_state <= S_DRAIN;
        end
        S_DRAIN:   if (!valid_in) r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
      // Any cycle without a sample either aborts a block or sits outside one.
      if (w_sample) begin
        r_shift[r_bit_idx] <= cipher_in;
        r_bit_idx          <= r_bit_idx + 3'd1;
        r_blk_cnt          <= w_last ? '0 : (r_blk_cnt + c_cnt_one);
      end else begin
        r_bit_idx <= 3'd0;
        r_blk_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_byte;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_byte_out   <= 8'h00;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      r_rd_ptr     <= w_rd_nxt;
      r_level      <= w_lvl_nxt;
      r_byte_out   <= w_head_nxt;
      r_byte_valid <= (w_lvl_nxt != '0);
      if (w_abort)          r_frame_err <= 1'b1;
      else if (clear_flags) r_frame_err <= 1'b0;
      if (w_drop)           r_overflow  <= 1'b1;
      else if (clear_flags) r_overflow  <= 1'b0;
    end
  end

  assign byte_out   = r_byte_out;
  assign byte_valid = r_byte_valid;
  assign block_done = r_block_done;
  assign frame_err  = r_frame_err;
  assign overflow   = r_overflow;
  assign fill_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_simon_output_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_simon_output_collector
// Purpose  : Scoreboard bench for simon_output_collector (directed blocks).
// Revision : 1.0 - initial release
// ============================================================================
module tb_simon_output_collector;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cipher_in = 1'b0;
  logic       valid_in = 1'b0;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ack = 1'b0;
  logic       block_done;
  logic       frame_err;
  logic       overflow;
  logic       clear_flags = 1'b0;
  logic [2:0] fill_level;

  int         total = 0;
  int         bad = 0;
  int         done_cnt = 0;
  int         lvl_at = 0;
  int         ovf_at = 0;
  logic [7:0] sb_q [$];

  // Hand-derived byte order of the reference block, LSB byte first.
  logic [7:0] ref_bytes [16] = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE,
                                 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
  logic [127:0] blk = 128'h0123456789ABCDEF_FEDCBA9876543210;

  simon_output_collector #(.BLOCK_BITS(128), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .cipher_in(cipher_in), .valid_in(valid_in),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ack(byte_ack),
    .block_done(block_done), .frame_err(frame_err), .overflow(overflow),
    .clear_flags(clear_flags), .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (block_done) done_cnt++;
    if (byte_valid && byte_ack) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_byte: got=%0h expected=none", byte_out);
      end else begin
        check("byte", {24'h0, byte_out}, {24'h0, sb_q.pop_front()});
      end
    end
  end

  task automatic send_block(input int nbits, input int extra, input int ack_from, input int n_exp);
    for (int k = 0; k < n_exp; k++) sb_q.push_back(ref_bytes[k]);
    for (int i = 0; i < nbits + extra; i++) begin
      @(posedge clk); #1;
      if (i == ack_from + 1) begin
        lvl_at = int'(fill_level);
        ovf_at = int'(overflow);
      end
      valid_in  = 1'b1;
      cipher_in = (i < nbits) ? blk[i] : 1'($urandom_range(0, 1));
      byte_ack  = (i >= ack_from);
    end
    @(posedge clk); #1;
    valid_in  = 1'b0;
    cipher_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    byte_ack = 1'b1;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain_empty", sb_q.size(), 0);
    check("fill_zero", {29'h0, fill_level}, 0);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    clear_flags = 1'b1;
    @(posedge clk); #1;
    clear_flags = 1'b0;
  endtask

  initial begin
    #12;
    check("reset_outputs", {17'h0, byte_out, byte_valid, block_done, frame_err, overflow, fill_level}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: nominal block, consumer always ready
    done_cnt = 0;
    send_block(128, 0, 0, 16);
    drain();
    check("t1_done", done_cnt, 1);
    check("t1_flags", {30'h0, frame_err, overflow}, 0);

    // 2: no acks for a whole block; FIFO keeps first four bytes
    done_cnt = 0;
    send_block(128, 0, 1000, 4);
    repeat (2) @(posedge clk); #1;
    check("t2_level", {29'h0, fill_level}, 4);
    check("t2_overflow", {31'h0, overflow}, 1);
    check("t2_done", done_cnt, 1);
    drain();
    pulse_clear();
    check("t2_cleared", {31'h0, overflow}, 0);

    // 3: valid drops after 13 bits, then a good block
    send_block(13, 0, 0, 1);
    drain();
    check("t3_frame_err", {31'h0, frame_err}, 1);
    done_cnt = 0;
    send_block(128, 0, 0, 16);
    drain();
    check("t3_done", done_cnt, 1);
    check("t3_sticky", {31'h0, frame_err}, 1);
    pulse_clear();
    check("t3_cleared", {31'h0, frame_err}, 0);

    // 4: FIFO full, pop and push share the edge of bit 39
    send_block(128, 0, 39, 16);
    drain();
    check("t4_level_at_push", lvl_at, 4);
    check("t4_no_ovf_at_push", ovf_at, 0);
    check("t4_overflow", {31'h0, overflow}, 0);

    // 5: valid held 20 extra cycles past the last bit
    done_cnt = 0;
    send_block(128, 20, 0, 16);
    drain();
    check("t5_done", done_cnt, 1);
    check("t5_frame_err", {31'h0, frame_err}, 0);

    // 6: async reset at bit 70 with a full FIFO and overflow pending
    byte_ack = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      valid_in  = 1'b1;
      cipher_in = blk[i];
    end
    @(posedge clk); #1;
    check("t6_pre_level", {29'h0, fill_level}, 4);
    check("t6_pre_ovf", {31'h0, overflow}, 1);
    cipher_in = blk[70];
    #2;
    reset    = 1'b1;
    valid_in = 1'b0;
    #1;
    check("t6_async_zero", {17'h0, byte_out, byte_valid, block_done, frame_err, overflow, fill_level}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    done_cnt = 0;
    send_block(128, 0, 0, 16);
    drain();
    check("t6_done", done_cnt, 1);
    check("t6_flags", {30'h0, frame_err, overflow}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
